// File: rtl/ibex_mem_arb_pkg.sv
// Shared types for the Ibex instruction/data memory arbiter.
package ibex_mem_arb_pkg;

  typedef enum logic {PRIO_INSTR, PRIO_DATA} prio_e;

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_I,
    OWN_D,
    OWN_ERR_I,
    OWN_ERR_D
  } owner_e;

  localparam int unsigned STARVE_CNT_W = 4;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] start,
                                         input logic [31:0] size);
    return (addr & ~(size - 32'd1)) == start;
  endfunction

endpackage

// File: rtl/ibex_mem_arbiter_if.sv
// Bundle of Ibex instr/data ports and the ram_1p port seen by the arbiter.
interface ibex_mem_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        conflict_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rvalid_i, mem_rdata_i,
    output conflict_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rvalid_i, mem_rdata_i,
    input  conflict_o
  );
endinterface

// File: rtl/ibex_mem_arb_prio.sv
// Priority FSM: instruction side wins by default, data side is promoted after
// STARVE_LIMIT-1 consecutive conflict losses.
module ibex_mem_arb_prio
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_sys,
  input  logic rst_sys_n,
  input  logic instr_req_i,
  input  logic data_req_i,
  input  logic data_gnt_i,
  output logic sel_data_o
);

  localparam logic [STARVE_CNT_W-1:0] CNT_LAST = STARVE_CNT_W'(STARVE_LIMIT - 1);

  prio_e                   prio_q, prio_d;
  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      prio_q <= PRIO_INSTR;
      cnt_q  <= '0;
    end else begin
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    sel_data_o = data_req_i & ((prio_q == PRIO_DATA) | ~instr_req_i);
    if (data_gnt_i) begin
      prio_d = PRIO_INSTR;
      cnt_d  = '0;
    end else if (instr_req_i & data_req_i) begin
      // data only loses in PRIO_INSTR, so the counter never passes CNT_LAST
      cnt_d = cnt_q + 1'b1;
      if (cnt_d >= CNT_LAST) prio_d = PRIO_DATA;
    end
  end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Shares one ram_1p between the Ibex instr and data ports with same-cycle grant.
// IBEX_MEM_ARB_ERR_RESP_EN: flag out-of-range accesses with err_o on the response.
module ibex_mem_arbiter
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MEM_SIZE     = 65536,
  parameter logic [31:0] MEM_START    = 32'h0000_0000
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  ibex_mem_arbiter_if.slave bus
);

`ifdef IBEX_MEM_ARB_ERR_RESP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        sel_data;
  logic        instr_gnt, data_gnt;
  logic [31:0] win_addr;
  logic        win_ok;
  owner_e      owner_q, owner_d;
  logic        we_q, we_d;

  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        i_rvalid, d_rvalid, i_err, d_err;
  logic [31:0] i_rdata, d_rdata;

  ibex_mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk_sys     (clk_sys),
    .rst_sys_n   (rst_sys_n),
    .instr_req_i (bus.instr_req_i),
    .data_req_i  (bus.data_req_i),
    .data_gnt_i  (data_gnt),
    .sel_data_o  (sel_data)
  );

  always_comb begin
    instr_gnt = bus.instr_req_i & ~sel_data;
    data_gnt  = bus.data_req_i & sel_data;
    win_addr  = sel_data ? bus.data_addr_i : bus.instr_addr_i;
    win_ok    = addr_in_range(win_addr, MEM_START, 32'(MEM_SIZE));

    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    we_d      = 1'b0;

    if (instr_gnt) begin
      owner_d = win_ok ? OWN_I : OWN_ERR_I;
      if (win_ok) begin
        mem_req  = 1'b1;
        mem_be   = 4'hF;
        mem_addr = bus.instr_addr_i;
      end
    end else if (data_gnt) begin
      owner_d = win_ok ? OWN_D : OWN_ERR_D;
      we_d    = bus.data_we_i;
      if (win_ok) begin
        mem_req   = 1'b1;
        mem_we    = bus.data_we_i;
        mem_be    = bus.data_be_i;
        mem_addr  = bus.data_addr_i;
        mem_wdata = bus.data_wdata_i;
      end
    end
  end

  // async reset drops any in-flight response along with the owner
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    i_err    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    d_err    = 1'b0;
    case (owner_q)
      OWN_I: begin
        i_rvalid = bus.mem_rvalid_i;
        i_rdata  = bus.mem_rdata_i;
      end
      OWN_D: begin
        d_rvalid = bus.mem_rvalid_i;
        d_rdata  = we_q ? 32'h0 : bus.mem_rdata_i;
      end
      OWN_ERR_I: begin
        i_rvalid = 1'b1;
        i_err    = ERR_EN;
      end
      OWN_ERR_D: begin
        d_rvalid = 1'b1;
        d_err    = ERR_EN;
      end
      default: ;
    endcase
  end

  assign bus.instr_gnt_o    = instr_gnt;
  assign bus.instr_rvalid_o = i_rvalid;
  assign bus.instr_rdata_o  = i_rdata;
  assign bus.instr_err_o    = i_err;
  assign bus.data_gnt_o     = data_gnt;
  assign bus.data_rvalid_o  = d_rvalid;
  assign bus.data_rdata_o   = d_rdata;
  assign bus.data_err_o     = d_err;
  assign bus.mem_req_o      = mem_req;
  assign bus.mem_we_o       = mem_we;
  assign bus.mem_be_o       = mem_be;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.mem_wdata_o    = mem_wdata;
  assign bus.conflict_o     = bus.instr_req_i & bus.data_req_i;

  // RAM responses are only expected for requests actually forwarded last cycle
  a_no_stray_rvalid: assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
    bus.mem_rvalid_i |-> (owner_q == OWN_I || owner_q == OWN_D))
    else $error("mem_rvalid_i without an outstanding RAM request");

endmodule
